// File: rtl/nios_fprint_oci_dct_pkg.sv
// Shared constants and FSM encoding for the OCI trace-code packer.
package nios_fprint_oci_dct_pkg;

    // Trace codes per emitted frame and width of a single code.
    localparam int DCT_ENTRIES = 15;
    localparam int DCT_CODE_W  = 2;

    // Session state of the packer.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENDING = 2'd1,
        ST_ENDED  = 2'd2
    } dct_state_e;

endpackage

// File: rtl/nios_fprint_processor2_0_cpu2_oci_dct_accum.sv
// Trace-code accumulator: appends accepted codes at the fill index and is
// cleared when its contents move to the output slot. A code written in the
// clear cycle lands in entry 0 of the emptied accumulator.
module nios_fprint_processor2_0_cpu2_oci_dct_accum #(
    parameter int DCT_ENTRIES = nios_fprint_oci_dct_pkg::DCT_ENTRIES,
    parameter int DCT_CODE_W  = nios_fprint_oci_dct_pkg::DCT_CODE_W,
    parameter int BUF_W       = DCT_ENTRIES * DCT_CODE_W,
    parameter int CNT_W       = $clog2(DCT_ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DCT_CODE_W-1:0] wr_code,
    input  logic                  clr,
    output logic [BUF_W-1:0]      acc_buf,
    output logic [CNT_W-1:0]      acc_cnt
);
    import nios_fprint_oci_dct_pkg::*;

    logic [BUF_W-1:0] buf_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next contents: optional clear first, then the new code at the fill index.
    always_comb begin
        buf_nxt = clr ? '0 : acc_buf;
        cnt_nxt = clr ? '0 : acc_cnt;
        if (wr_en) begin
            for (int i = 0; i < DCT_ENTRIES; i++) begin
                if (cnt_nxt == CNT_W'(i)) begin
                    buf_nxt[i*DCT_CODE_W +: DCT_CODE_W] = wr_code;
                end
            end
            cnt_nxt = cnt_nxt + 1'b1;
        end
    end

    // Accumulator registers; unused entries stay zero because clears zero them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_buf <= '0;
            acc_cnt <= '0;
        end else begin
            acc_buf <= buf_nxt;
            acc_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/nios_fprint_processor2_0_cpu2_oci_dct_packer.sv
// Packs 2-bit trace codes into 15-entry frames behind a one-deep output slot,
// with flush of partial frames and an end-of-session sequence.
module nios_fprint_processor2_0_cpu2_oci_dct_packer #(
    parameter int DCT_ENTRIES = nios_fprint_oci_dct_pkg::DCT_ENTRIES,
    parameter int DCT_CODE_W  = nios_fprint_oci_dct_pkg::DCT_CODE_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DCT_CODE_W-1:0]                 code_in,
    input  logic                                  code_valid,
    output logic                                  code_ready,
    input  logic                                  flush,
    input  logic                                  end_req,
    output logic [DCT_ENTRIES*DCT_CODE_W-1:0]     dct_buffer,
    output logic [$clog2(DCT_ENTRIES+1)-1:0]      dct_count,
    output logic                                  frame_valid,
    input  logic                                  out_ready,
    output logic                                  test_ending,
    output logic                                  test_has_ended
);
    import nios_fprint_oci_dct_pkg::*;

    localparam int BUF_W = DCT_ENTRIES * DCT_CODE_W;
    localparam int CNT_W = $clog2(DCT_ENTRIES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DCT_ENTRIES);

    dct_state_e       state, state_nxt;
    logic [BUF_W-1:0] acc_buf;
    logic [CNT_W-1:0] acc_cnt;
    logic             flush_pend, flush_pend_nxt;
    logic             slot_free, transfer, accept, flush_eff, empty_after;

    assign slot_free   = !frame_valid || out_ready;
    assign transfer    = (acc_cnt == FULL_CNT || flush_pend) && (acc_cnt != '0) && slot_free;
    assign code_ready  = (state == ST_RUN) && (acc_cnt != FULL_CNT || transfer);
    assign accept      = code_valid && code_ready;
    assign flush_eff   = (state == ST_RUN) && (flush || end_req);
    // Accumulator holds nothing after this edge: a pending flush has nothing to emit.
    assign empty_after = !accept && (transfer || acc_cnt == '0);

    nios_fprint_processor2_0_cpu2_oci_dct_accum #(
        .DCT_ENTRIES (DCT_ENTRIES),
        .DCT_CODE_W  (DCT_CODE_W),
        .BUF_W       (BUF_W),
        .CNT_W       (CNT_W)
    ) u_accum (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_code (code_in),
        .clr     (transfer),
        .acc_buf (acc_buf),
        .acc_cnt (acc_cnt)
    );

    // Pending-flush bookkeeping: set by flush/end, cleared by transfer or emptiness.
    always_comb begin
        flush_pend_nxt = transfer ? 1'b0 : flush_pend;
        if (flush_eff) begin
            flush_pend_nxt = 1'b1;
        end
        if (empty_after) begin
            flush_pend_nxt = 1'b0;
        end
    end

    // Session FSM next state and status outputs.
    always_comb begin
        state_nxt      = state;
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        case (state)
            ST_RUN: begin
                if (end_req) begin
                    state_nxt = ST_ENDING;
                end
            end
            ST_ENDING: begin
                test_ending = 1'b1;
                if (acc_cnt == '0 && !frame_valid) begin
                    state_nxt = ST_ENDED;
                end
            end
            ST_ENDED: begin
                test_has_ended = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Control registers: session state and pending flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // One-deep output slot: load on transfer, drop valid once the sink takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            dct_buffer  <= '0;
            dct_count   <= '0;
        end else if (transfer) begin
            frame_valid <= 1'b1;
            dct_buffer  <= acc_buf;
            dct_count   <= acc_cnt;
        end else if (out_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nios_fprint_processor2_0_cpu2_oci_dct_packer.sv
// Self-checking bench for the trace-code packer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_nios_fprint_processor2_0_cpu2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  code_in;
    logic        code_valid, code_ready, flush, end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid, out_ready, test_ending, test_has_ended;

    int checks   = 0;
    int failures = 0;

    // Reference model: accumulator as a code queue, slot contents, session phase.
    int          m_acc[$];
    bit          m_pend;
    int          m_state;   // 0 running, 1 ending, 2 ended
    bit          m_fv;
    logic [29:0] m_buf;
    int          m_cnt;
    int          n_acc;

    // Frames observed at the sink handshake, taken from the DUT outputs.
    logic [29:0] rx_buf[$];
    int          rx_cnt[$];

    logic [29:0] e1, e2;

    always #5 clk = ~clk;

    nios_fprint_processor2_0_cpu2_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .code_in        (code_in),
        .code_valid     (code_valid),
        .code_ready     (code_ready),
        .flush          (flush),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .out_ready      (out_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc.delete();
        m_pend  = 1'b0;
        m_state = 0;
        m_fv    = 1'b0;
        m_buf   = '0;
        m_cnt   = 0;
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance the model.
    task automatic cycle(input bit v, input logic [1:0] c, input bit fl, input bit er, input bit ordy);
        bit full, sfree, xfer, rdy, acc, old_fv;
        int old_size;
        code_valid = v;
        code_in    = c;
        flush      = fl;
        end_req    = er;
        out_ready  = ordy;
        #4;
        full  = (m_acc.size() == 15);
        sfree = !m_fv || ordy;
        xfer  = (full || m_pend) && (m_acc.size() != 0) && sfree;
        rdy   = (m_state == 0) && (!full || xfer);
        check_val("code_ready", 32'(code_ready), 32'(rdy));
        check_val("frame_valid", 32'(frame_valid), 32'(m_fv));
        check_val("dct_buffer", 32'(dct_buffer), 32'(m_buf));
        check_val("dct_count", 32'(dct_count), 32'(m_cnt));
        check_val("test_ending", 32'(test_ending), 32'(m_state == 1));
        check_val("test_has_ended", 32'(test_has_ended), 32'(m_state == 2));
        if (frame_valid && ordy) begin
            rx_buf.push_back(dct_buffer);
            rx_cnt.push_back(int'(dct_count));
        end
        acc = v && rdy;
        if (acc) n_acc++;
        old_size = m_acc.size();
        old_fv   = m_fv;
        if (xfer) begin
            m_buf = '0;
            foreach (m_acc[i]) m_buf[2*i +: 2] = m_acc[i][1:0];
            m_cnt = m_acc.size();
            m_fv  = 1'b1;
            m_acc.delete();
            m_pend = 1'b0;
        end else if (ordy) begin
            m_fv = 1'b0;
        end
        if (acc) m_acc.push_back(int'(c));
        if (m_state == 0 && (fl || er)) m_pend = 1'b1;
        // A pending flush with an empty accumulator has nothing to emit.
        if (m_acc.size() == 0) m_pend = 1'b0;
        if (m_state == 0 && er) m_state = 1;
        else if (m_state == 1 && old_size == 0 && !old_fv) m_state = 2;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        code_valid = 1'b0;
        code_in    = 2'b00;
        flush      = 1'b0;
        end_req    = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_frame_valid", 32'(frame_valid), 32'(0));
        check_val("rst_dct_buffer", 32'(dct_buffer), 32'(0));
        check_val("rst_dct_count", 32'(dct_count), 32'(0));
        check_val("rst_test_ending", 32'(test_ending), 32'(0));
        check_val("rst_test_has_ended", 32'(test_has_ended), 32'(0));
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 15; k++) begin
            e1[2*k +: 2] = 2'(k % 4);
            e2[2*k +: 2] = 2'((k + 15) % 4);
        end
        do_reset();

        // Full frame of 2'b11 codes.
        rx_buf.delete(); rx_cnt.delete();
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("full_frames", 32'(rx_buf.size()), 32'(1));
        if (rx_buf.size() >= 1) begin
            check_val("full_buf", 32'(rx_buf[0]), 32'h3FFF_FFFF);
            check_val("full_cnt", 32'(rx_cnt[0]), 32'(15));
        end

        // Partial flush of three 2'b01 codes.
        rx_buf.delete(); rx_cnt.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("flush_frames", 32'(rx_buf.size()), 32'(1));
        if (rx_buf.size() >= 1) begin
            check_val("flush_buf", 32'(rx_buf[0]), 32'h0000_0015);
            check_val("flush_cnt", 32'(rx_cnt[0]), 32'(3));
        end

        // Flush with an empty accumulator emits nothing.
        rx_buf.delete(); rx_cnt.delete();
        cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("empty_flush_frames", 32'(rx_buf.size()), 32'(0));
        check_val("empty_flush_fv", 32'(frame_valid), 32'(0));

        // Backpressure: 31 codes offered with the sink stalled.
        rx_buf.delete(); rx_cnt.delete();
        n_acc = 0;
        for (int i = 0; i < 31; i++) cycle(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b0);
        check_val("bp_accepted", 32'(n_acc), 32'(30));
        check_val("bp_code_ready", 32'(code_ready), 32'(0));
        repeat (3) cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check_val("bp_hold_fv", 32'(frame_valid), 32'(1));
        check_val("bp_hold_buf", 32'(dct_buffer), 32'(e1));
        repeat (4) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("bp_frames", 32'(rx_buf.size()), 32'(2));
        if (rx_buf.size() >= 2) begin
            check_val("bp_buf0", 32'(rx_buf[0]), 32'(e1));
            check_val("bp_buf1", 32'(rx_buf[1]), 32'(e2));
            check_val("bp_cnt0", 32'(rx_cnt[0]), 32'(15));
            check_val("bp_cnt1", 32'(rx_cnt[1]), 32'(15));
        end

        // End of session after five codes 0,1,2,3,0.
        rx_buf.delete(); rx_cnt.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        check_val("end_ending", 32'(test_ending), 32'(1));
        repeat (4) cycle(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        check_val("end_frames", 32'(rx_buf.size()), 32'(1));
        if (rx_buf.size() >= 1) begin
            check_val("end_buf", 32'(rx_buf[0]), 32'h0000_00E4);
            check_val("end_cnt", 32'(rx_cnt[0]), 32'(5));
        end
        check_val("end_has_ended", 32'(test_has_ended), 32'(1));
        repeat (3) cycle(1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
        check_val("end_code_ready", 32'(code_ready), 32'(0));
        check_val("end_sticky", 32'(test_has_ended), 32'(1));

        // Asynchronous reset between clock edges with a held frame.
        do_reset();
        rx_buf.delete(); rx_cnt.delete();
        for (int i = 0; i < 19; i++) cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check_val("async_pre_fv", 32'(frame_valid), 32'(1));
        code_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("async_fv", 32'(frame_valid), 32'(0));
        check_val("async_buf", 32'(dct_buffer), 32'(0));
        check_val("async_cnt", 32'(dct_count), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("async_frames", 32'(rx_buf.size()), 32'(1));
        if (rx_buf.size() >= 1) begin
            check_val("async_clean_buf", 32'(rx_buf[0]), 32'(e1));
            check_val("async_clean_cnt", 32'(rx_cnt[0]), 32'(15));
        end

        // Randomized traffic, then a closing end request.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 19) == 0, 1'b0, $urandom_range(0, 3) != 0);
        end
        cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b1);
        repeat (40) cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_val("rnd_has_ended", 32'(test_has_ended), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_fprint_processor2_0_cpu2_oci_dct_packer.md
NIOS_FPRINT_PROCESSOR2_0_CPU2_OCI_DCT_PACKER -- requirements
Module: nios_fprint_processor2_0_cpu2_oci_dct_packer

Interface
REQ-001 SHALL have parameter DCT_ENTRIES, default 15, meaning the number of 2-bit trace codes per frame.
REQ-002 SHALL have parameter DCT_CODE_W, default 2, meaning the width of one trace code.
REQ-003 Port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port code_in, input, 2: the trace code offered.
REQ-006 Port code_valid, input, 1: code_in is offered this cycle.
REQ-007 Port code_ready, output, 1: the code is accepted when code_valid && code_ready.
REQ-008 Port flush, input, 1: one-cycle request to emit a partial frame.
REQ-009 Port end_req, input, 1: one-cycle request to end the trace session.
REQ-010 Port dct_buffer, output, 30: packed frame; entry i occupies bits [2i+1:2i].
REQ-011 Port dct_count, output, 4: number of valid entries in dct_buffer (1..15).
REQ-012 Port frame_valid, output, 1: dct_buffer and dct_count hold a frame.
REQ-013 Port out_ready, input, 1: the sink accepts the frame when frame_valid && out_ready.
REQ-014 Port test_ending, output, 1: session end is in progress.
REQ-015 Port test_has_ended, output, 1: session is complete; sticky.

Function
REQ-016 Accumulator (acc_buf 30b, acc_cnt 4b): an accepted code SHALL be written to entry acc_cnt, and acc_cnt SHALL increment.
REQ-017 Output slot (one deep) SHALL be "free" when !frame_valid || out_ready.
REQ-018 Transfer SHALL occur when (acc_cnt==15 || flush_pend) && acc_cnt!=0 && slot free.
- On transfer: dct_buffer<=acc_buf, dct_count<=acc_cnt, frame_valid<=1; acc cleared; flush_pend cleared.
REQ-019 A code accepted in a transfer cycle SHALL land in entry 0 of the cleared accumulator (acc_cnt becomes 1); no code is lost or duplicated.
REQ-020 code_ready SHALL be 0 when state!=RUN, or when acc_cnt==15 and no transfer occurs this cycle; otherwise it SHALL be 1.
REQ-021 Entries at or above acc_cnt SHALL be zero in any emitted dct_buffer.
REQ-022 flush SHALL set flush_pend; a flush with acc_cnt==0 and no code accepted that cycle SHALL emit nothing and SHALL clear flush_pend.
REQ-023 flush coincident with an accepted code SHALL include that code in the flushed frame.
REQ-024 When frame_valid && !out_ready, dct_buffer, dct_count and frame_valid SHALL hold stable.
REQ-025 When frame_valid && out_ready and no transfer occurs, frame_valid SHALL go to 0 next cycle; dct_buffer and dct_count SHALL keep their last values.
REQ-026 Latency: the 15th accepted code at cycle N SHALL yield frame_valid at N+2 when the slot is free.
REQ-027 FSM states and transitions:
- RUN: on end_req, go to ENDING and force flush_pend.
- ENDING: when acc_cnt==0 and !frame_valid, go to ENDED.
- ENDED: terminal until reset.
REQ-028 test_ending SHALL be 1 exactly in ENDING; test_has_ended SHALL be 1 exactly in ENDED.
REQ-029 end_req and flush in ENDING or ENDED SHALL be ignored.
REQ-030 A code accepted in the same cycle as end_req SHALL be included in the final frame.

Reset
REQ-031 While reset=1, regardless of clk: acc cleared, flush_pend=0, state=RUN, frame_valid=0, dct_buffer=0, dct_count=0, test_ending=0, test_has_ended=0.
REQ-032 Reset mid-frame or mid-ENDING SHALL discard all pending data; code_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-033 DCT_ENTRIES, DCT_CODE_W and the FSM state encodings (RUN=0, ENDING=1, ENDED=2) SHALL live in shared package nios_fprint_oci_dct_pkg.
REQ-034 Accumulator write/clear logic SHALL be a sub-module, nios_fprint_processor2_0_cpu2_oci_dct_accum; the output slot and FSM stay in the top module.

Verification
REQ-035 Full frame: 15 codes of 2'b11, out_ready=1 -> one frame, dct_buffer=30'h3FFFFFFF, dct_count=4'hF.
REQ-036 Partial flush: codes 01,01,01, then flush -> dct_buffer=30'h00000015, dct_count=3.
REQ-037 Backpressure: out_ready=0, 31 codes offered -> code_ready drops after the 30th accepted code; outputs stay stable; raising out_ready drains frames 1 and 2 in order with no loss.
REQ-038 End: 5 codes then end_req -> test_ending=1, frame dct_count=5, then test_has_ended=1, and code_ready stays 0.
REQ-039 Empty flush: flush with acc_cnt=0 -> frame_valid stays 0.
REQ-040 Async reset: reset asserted mid-frame between clock edges -> outputs go to 0 immediately; the next 15 codes form a clean frame.
